window_avg_reg: RTL
===================

# window_avg_reg

Parametrised sliding-window sample register for the temperature-sensor datapath. It is the successor to the single-stage enabled register. Each accepted ADC sample is stored in a DEPTH-deep shift register, and the block maintains a running sum and a power-of-two average over the window. It sits between the ADC sample capture stage and the display/threshold logic, where it supplies a noise-filtered reading and the oldest (delayed) raw sample.

## Interface
- DATA_WIDTH, 12, width of one unsigned sample
- DEPTH, 8, window length in samples; power of two, ≥ 2
- Derived (not overridable): LOG2D = log2(DEPTH); SUM_WIDTH = DATA_WIDTH + LOG2D; CNT_WIDTH = LOG2D + 1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; when low, all state holds
- clr  in  1  synchronous window flush; same effect as rst
- d  in  DATA_WIDTH  incoming sample, unsigned
- d_valid  in  1  d is a new sample this cycle
- q  out  DATA_WIDTH  oldest stored sample (stage DEPTH-1)
- q_valid  out  1  window is full; q holds a real sample
- sum  out  SUM_WIDTH  sum of all stored stages
- avg  out  DATA_WIDTH  sum >> LOG2D (floor)
- count  out  CNT_WIDTH  samples held, saturates at DEPTH
- full  out  1  count == DEPTH

## Operation
- Storage: stage[0..DEPTH-1], each DATA_WIDTH bits. Stage 0 is the newest sample. Empty stages hold 0.
- Priority per edge: rst > clr > (en & d_valid) > hold.
- rst or clr: all stages, sum, and count go to 0. en is ignored.
- Accept (en & d_valid, no rst/clr):
  - stage[0] <= d; stage[i] <= stage[i-1] for i = 1..DEPTH-1.
  - sum <= sum + d − stage[DEPTH-1]. Compute this at SUM_WIDTH. It cannot overflow or underflow, because empty stages are 0.
  - count <= count + 1 while count < DEPTH, else it holds at DEPTH.
- en low, or d_valid low: every register holds. There is no bubble insertion.
- Outputs:
  - q = stage[DEPTH-1]
  - avg = sum[SUM_WIDTH-1:LOG2D]
  - full = (count == DEPTH)
  - q_valid = full
- Before the window is full, avg is sum/DEPTH with zeros filling the window. It is not the mean of the received samples. Downstream logic gates on full.
- No internal FSM beyond the fill counter. The counter has two regimes:
  - FILLING: count < DEPTH
  - FULL: count == DEPTH. The block leaves FULL only on rst or clr.

## Timing
- Every output is a register or a pure slice/compare of registers. There is no combinational path from d, d_valid, en, or clr to any output.
- Reset values: q = 0, q_valid = 0, sum = 0, avg = 0, count = 0, full = 0.
- Latency:
  - A sample accepted at edge k is reflected in sum, avg, and count after edge k (visible in cycle k+1).
  - That sample reaches q after the DEPTH-th accept counted from and including its own, at the earliest DEPTH accepted cycles later.
- full and q_valid rise in the cycle after the DEPTH-th accept.
- Back-to-back accepts every cycle are supported, at full throughput.
- clr or rst asserted in the same cycle as d_valid: the sample is dropped, and the block is empty next cycle.
- Reset mid-operation has no partial effect. All state is cleared on that edge.

## Test plan
- Reset: assert rst for 2 cycles with en = 1, d_valid = 1, d = 0xABC. Required: all outputs 0 and count = 0 after release.
- Fill: accept d = 1..8 on consecutive cycles with DEPTH = 8.
  - After the 7th accept: count = 7, full = 0, sum = 28.
  - After the 8th accept: sum = 36, avg = 4, q = 1, full = 1, q_valid = 1.
- Slide: continuing from Fill, accept d = 100. Required: sum = 135, avg = 16, q = 2, count = 8.
- Hold: from the full window, drive en = 0 with d_valid = 1 for 5 cycles, then en = 1 and d_valid = 0 for 3 cycles. Required: sum, q, and count unchanged throughout.
- Extremes: accept 8 × 4095. Required: sum = 32760, avg = 4095, with no wrap. Then accept 8 × 0. Required: sum = 0, with no underflow at any step.
- Flush priority:
  - Mid-fill (count = 5), assert clr with d_valid = 1. Required: count = 0 and sum = 0 next cycle; the sample is dropped.
  - Assert rst and clr together. Required: same result as rst alone.

Source files
------------

// File: rtl/window_avg_reg_if.sv
// Sample/result bundle for the sliding-window register.
// master drives samples and control; slave is the window register itself.
interface window_avg_reg_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 8
) ();
  localparam int unsigned LOG2D     = $clog2(DEPTH);
  localparam int unsigned SUM_WIDTH = DATA_WIDTH + LOG2D;
  localparam int unsigned CNT_WIDTH = LOG2D + 1;

  logic                  en;
  logic                  clr;
  logic [DATA_WIDTH-1:0] d;
  logic                  d_valid;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic [SUM_WIDTH-1:0]  sum;
  logic [DATA_WIDTH-1:0] avg;
  logic [CNT_WIDTH-1:0]  count;
  logic                  full;

  modport master (
    output en, clr, d, d_valid,
    input  q, q_valid, sum, avg, count, full
  );

  modport slave (
    input  en, clr, d, d_valid,
    output q, q_valid, sum, avg, count, full
  );
endinterface

// File: rtl/window_avg_reg.sv
// Sliding-window sample register: DEPTH-deep shift register with a running
// sum, power-of-two floor average, and a saturating fill counter.
module window_avg_reg #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 8
) (
  input  logic              clk,
  input  logic              rst,
  window_avg_reg_if.slave   bus
);
  localparam int unsigned LOG2D     = $clog2(DEPTH);
  localparam int unsigned SUM_WIDTH = DATA_WIDTH + LOG2D;
  localparam int unsigned CNT_WIDTH = LOG2D + 1;

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];
  logic [DATA_WIDTH-1:0] stage_d [DEPTH];
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full;

  assign full = (count_q == CNT_WIDTH'(DEPTH));

  // Next-state: clr flushes, an accepted sample shifts in, otherwise hold.
  always_comb begin
    stage_d = stage_q;
    sum_d   = sum_q;
    count_d = count_q;
    if (bus.clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = '0;
      sum_d   = '0;
      count_d = '0;
    end else if (bus.en && bus.d_valid) begin
      stage_d[0] = bus.d;
      for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      // Empty stages hold 0, so the running sum never wraps either way.
      sum_d = sum_q + SUM_WIDTH'(bus.d) - SUM_WIDTH'(stage_q[DEPTH-1]);
      if (!full) count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign bus.q       = stage_q[DEPTH-1];
  assign bus.sum     = sum_q;
  assign bus.avg     = sum_q[SUM_WIDTH-1:LOG2D];
  assign bus.count   = count_q;
  assign bus.full    = full;
  assign bus.q_valid = full;
endmodule
